sync_bus_capture_ctrl: RTL
==========================

Name: sync_bus_capture_ctrl

Overview:
Destination-domain controller that sequences a wide double-flop synchronizer bank for a slowly-changing multi-bit bus. On request it enables the synchronizer and waits for the 2-stage pipeline to flush. It then accepts the synchronized word only after it has been identical for STABLE_CYCLES consecutive cycles. The result is a qualified, coherent word plus a one-cycle valid pulse; a bus that never settles raises a timeout error.

Parameters:
WIDTH, 8, bus width; must match the synchronizer bank
STABLE_CYCLES, 3, consecutive matching samples required before capture; 1..255
TIMEOUT_CYCLES, 16, maximum WATCH cycles before error; must be >= STABLE_CYCLES and <= 65535

Ports:
clk  input  1  destination clock; single clock domain
rst  input  1  synchronous, active-high reset
start  input  1  capture request; sampled only in IDLE
sync_data  input  WIDTH  output of the synchronizer bank
sync_enable  output  1  drives the synchronizer bank enable
busy  output  1  high in FLUSH and WATCH
data  output  WIDTH  last captured word; held until the next capture
valid  output  1  one-cycle pulse when data is updated
timeout_error  output  1  one-cycle pulse on timeout

Behaviour:
- Reset (rst high at an edge): state IDLE; data=0, valid=0, timeout_error=0, busy=0, sync_enable=0; all counters and prev register cleared.
- rst asserted mid-operation aborts the capture; no valid or error pulse is produced.
- States: IDLE, FLUSH, WATCH. All outputs are registered. sync_enable = busy = (state != IDLE).
- Edge numbering: E0 is the edge that samples start=1 in IDLE; E1, E2, ... are the following edges.
- IDLE: start=1 -> FLUSH at E0. start while busy is ignored, not queued.
- IDLE with start=1 in the same cycle valid or timeout_error is high: accepted.
- FLUSH: lasts exactly 2 cycles (after E0, after E1).
- At E2: prev <= sync_data, stable_cnt <= 0, watch_cnt <= 0, state -> WATCH.
- WATCH, each edge:
  - If sync_data == prev: stable_cnt++.
  - Otherwise: prev <= sync_data, stable_cnt <= 0.
  - watch_cnt++ in either case.
- Success: at an edge where sync_data == prev and stable_cnt == STABLE_CYCLES-1, data <= sync_data, valid pulses for one cycle, state -> IDLE.
- Timeout: at the edge where watch_cnt == TIMEOUT_CYCLES-1 (the TIMEOUT_CYCLES-th WATCH edge) with no success, timeout_error pulses for one cycle, state -> IDLE, and data is unchanged.
- Simultaneous success and timeout on the same edge: success wins; no error pulse.
- Latency, constant input: valid is high in the cycle after edge E(2+STABLE_CYCLES); busy drops at that same edge.
- Counter widths: stable_cnt uses 8 bits, watch_cnt uses 16 bits. Neither counter wraps within legal parameter ranges.
- valid and timeout_error are never high together.

Test Plan:
1. Reset: rst high for 2 cycles -> data=0x00, valid=0, timeout_error=0, busy=0, sync_enable=0.
2. Constant input (WIDTH=8, STABLE=3, TIMEOUT=16): sync_data=0xA5, start at E0 -> busy/sync_enable high after E0; valid single pulse after E5; data=0xA5; busy low after E5.
3. Input change (same parameters): sync_data=0x11 through E3, 0x22 from E4 on -> mismatch at E4; valid after E7 with data=0x22.
4. Toggling input (same parameters): sync_data alternates 0x00/0xFF every cycle -> timeout_error pulse after E18; valid never asserts; data keeps its previous value (0x22 from scenario 3).
5. Start handling (same parameters):
   - start held high E1..E4 -> ignored; exactly one valid.
   - start high in the valid cycle -> second capture begins; its valid arrives 5 edges later.
6. Mid-operation reset (same parameters): rst at E4 -> IDLE next cycle; outputs at reset values; no valid/error. A new start then completes normally with data=constant input.

Source files
------------

// File: rtl/sync_bus_capture_ctrl.sv
// Destination-domain sequencer for a double-flop synchronizer bank: flushes the
// pipeline, then qualifies the synchronized word once it has held steady long enough.
module sync_bus_capture_ctrl #(
  parameter int WIDTH          = 8,
  parameter int STABLE_CYCLES  = 3,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] sync_data,
  output logic             sync_enable,
  output logic             busy,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             timeout_error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    WATCH = 2'd2
  } state_t;

  localparam logic [7:0]  STABLE_LAST  = 8'(STABLE_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic             flush_cnt_q, flush_cnt_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [7:0]       stable_cnt_q, stable_cnt_d;
  logic [15:0]      watch_cnt_q, watch_cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             timeout_error_q, timeout_error_d;
  logic             busy_q, busy_d;

  logic match_s, success_s, timeout_s;

  assign match_s   = (sync_data == prev_q);
  assign success_s = match_s && (stable_cnt_q == STABLE_LAST);
  assign timeout_s = (watch_cnt_q == TIMEOUT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      flush_cnt_q     <= 1'b0;
      prev_q          <= '0;
      stable_cnt_q    <= 8'd0;
      watch_cnt_q     <= 16'd0;
      data_q          <= '0;
      valid_q         <= 1'b0;
      timeout_error_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      flush_cnt_q     <= flush_cnt_d;
      prev_q          <= prev_d;
      stable_cnt_q    <= stable_cnt_d;
      watch_cnt_q     <= watch_cnt_d;
      data_q          <= data_d;
      valid_q         <= valid_d;
      timeout_error_q <= timeout_error_d;
      busy_q          <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = FLUSH;
        else       state_d = IDLE;
      end
      FLUSH: begin
        if (flush_cnt_q) state_d = WATCH;
        else             state_d = FLUSH;
      end
      WATCH: begin
        if (success_s || timeout_s) state_d = IDLE;
        else                        state_d = WATCH;
      end
      default: state_d = IDLE;
    endcase
  end

  // Success is checked before timeout so a capture on the last WATCH edge still wins.
  always_comb begin
    flush_cnt_d     = flush_cnt_q;
    prev_d          = prev_q;
    stable_cnt_d    = stable_cnt_q;
    watch_cnt_d     = watch_cnt_q;
    data_d          = data_q;
    valid_d         = 1'b0;
    timeout_error_d = 1'b0;
    busy_d          = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        flush_cnt_d = 1'b0;
      end
      FLUSH: begin
        flush_cnt_d = 1'b1;
        if (flush_cnt_q) begin
          prev_d       = sync_data;
          stable_cnt_d = 8'd0;
          watch_cnt_d  = 16'd0;
        end else begin
          prev_d = prev_q;
        end
      end
      WATCH: begin
        watch_cnt_d = watch_cnt_q + 16'd1;
        if (match_s) begin
          stable_cnt_d = stable_cnt_q + 8'd1;
        end else begin
          prev_d       = sync_data;
          stable_cnt_d = 8'd0;
        end
        if (success_s) begin
          data_d  = sync_data;
          valid_d = 1'b1;
        end else if (timeout_s) begin
          timeout_error_d = 1'b1;
        end else begin
          valid_d = 1'b0;
        end
      end
      default: begin
        flush_cnt_d = 1'b0;
      end
    endcase
  end

  assign sync_enable   = busy_q;
  assign busy          = busy_q;
  assign data          = data_q;
  assign valid         = valid_q;
  assign timeout_error = timeout_error_q;

endmodule
